// File: rtl/la_debounce.sv
// Pad-input conditioner: multi-flop synchronizer followed by a stability-count filter
// producing a clean level plus registered one-cycle rise/fall pulses.
module la_debounce #(
    parameter int SYNCSTAGES = 2,
    parameter int CW         = 16,
    parameter     PROP       = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          a,
    input  logic          en,
    input  logic [CW-1:0] cfg_limit,
    output logic          z,
    output logic          rise,
    output logic          fall,
    output logic          busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    logic [SYNCSTAGES-1:0] sync_q;
    logic                  a_s;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  z_q, z_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNCSTAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge nreset) begin
                    if (!nreset) sync_q[gi] <= 1'b0;
                    else         sync_q[gi] <= a;
                end
            end else begin : g_chain
                always_ff @(posedge clk or negedge nreset) begin
                    if (!nreset) sync_q[gi] <= 1'b0;
                    else         sync_q[gi] <= sync_q[gi-1];
                end
            end
        end

        // Technology-specific variants swap in their own synchronizer cell here.
        if (PROP == "DEFAULT") begin : g_generic
            assign a_s = sync_q[SYNCSTAGES-1];
        end else begin : g_tech
            assign a_s = sync_q[SYNCSTAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The >= test caps cnt at cfg_limit, so the counter can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        z_d     = z_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (a_s != z_q)) state_d = CHECK;
            end
            CHECK: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (a_s == z_q) begin
                    state_d = IDLE;
                end else if (cnt_q >= cfg_limit) begin
                    z_d     = a_s;
                    rise_d  = a_s;
                    fall_d  = ~a_s;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign z    = z_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == CHECK);

endmodule

// File: tb/tb_la_debounce.sv
// Directed bench for la_debounce: expected pulses are queued with their cycle
// when stimulus is applied and matched by a monitor thread as pulses appear.
module tb_la_debounce;

    localparam int SYNC = 2;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          nreset;
    logic          a;
    logic          en;
    logic [CW-1:0] cfg_limit;
    logic          z, rise, fall, busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_rise;
        int cyc;
    } pulse_t;
    pulse_t exp_q[$];

    la_debounce #(.SYNCSTAGES(SYNC), .CW(CW), .PROP("DEFAULT")) dut (
        .clk      (clk),
        .nreset   (nreset),
        .a        (a),
        .en       (en),
        .cfg_limit(cfg_limit),
        .z        (z),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse expected at cycle: drive cycle + synchronizer depth + limit + 2.
    task automatic expect_pulse(input bit is_rise, input int lim);
        pulse_t p;
        p.is_rise = is_rise;
        p.cyc     = cyc + SYNC + lim + 2;
        exp_q.push_back(p);
    endtask

    initial begin
        int k;
        nreset    = 1'b1;
        a         = 1'b1;
        en        = 1'b1;
        cfg_limit = 16'd3;

        fork
            forever begin
                pulse_t p;
                @(negedge clk);
                if (rise || fall) begin
                    $display("pulse %s at cycle %0d", rise ? "rise" : "fall", cyc);
                    chk("rise_fall_exclusive", {31'b0, rise & fall}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {30'b0, rise, fall}, 32'd0);
                    end else begin
                        p = exp_q.pop_front();
                        chk("pulse_dir", {31'b0, rise}, {31'b0, p.is_rise});
                        chk("pulse_cycle", cyc, p.cyc);
                    end
                end
            end
        join_none

        // Asynchronous reset before any clock edge.
        #1 nreset = 1'b0;
        #1;
        chk("reset_z", {31'b0, z}, 32'd0);
        chk("reset_rise", {31'b0, rise}, 32'd0);
        chk("reset_fall", {31'b0, fall}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        step(3);
        chk("reset_hold_z", {31'b0, z}, 32'd0);

        // Release with a held high, limit 3: busy for 4 cycles then rise.
        nreset = 1'b1;
        k = cyc;
        expect_pulse(1'b1, 3);
        $display("release reset at cycle %0d, limit 3", k);
        for (int i = 1; i <= 9; i++) begin
            step(1);
            chk("rel_busy", {31'b0, busy}, {31'b0, (cyc >= k + 3) && (cyc <= k + 6)});
            chk("rel_z", {31'b0, z}, {31'b0, cyc >= k + 7});
        end

        // Bring z low, then bounce with limit 5.
        cfg_limit = 16'd5;
        a = 1'b0;
        expect_pulse(1'b0, 5);
        $display("step a=0 at cycle %0d, limit 5", cyc);
        step(12);
        chk("bounce_pre_z", {31'b0, z}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            a = ~a;
            $display("bounce a=%0d at cycle %0d", a, cyc);
            step(2);
            chk("bounce_hold_z", {31'b0, z}, 32'd0);
        end
        a = 1'b1;
        expect_pulse(1'b1, 5);
        $display("final a=1 at cycle %0d", cyc);
        step(12);
        chk("bounce_z", {31'b0, z}, 32'd1);
        chk("bounce_busy", {31'b0, busy}, 32'd0);

        // Glitch shorter than limit+2 is rejected.
        cfg_limit = 16'd4;
        a = 1'b0;
        $display("glitch a=0 for 3 cycles at cycle %0d", cyc);
        step(3);
        a = 1'b1;
        step(10);
        chk("glitch_z", {31'b0, z}, 32'd1);
        chk("glitch_busy", {31'b0, busy}, 32'd0);

        // Limit 0: z follows in 2 cycles after a_s.
        cfg_limit = 16'd0;
        a = 1'b0;
        expect_pulse(1'b0, 0);
        $display("limit 0 step a=0 at cycle %0d", cyc);
        step(6);
        chk("lim0_fall_z", {31'b0, z}, 32'd0);
        a = 1'b1;
        expect_pulse(1'b1, 0);
        $display("limit 0 step a=1 at cycle %0d", cyc);
        step(6);
        chk("lim0_rise_z", {31'b0, z}, 32'd1);

        // Maximum limit: no counter wrap, 65537 cycles after a_s.
        cfg_limit = 16'hFFFF;
        a = 1'b0;
        k = cyc;
        expect_pulse(1'b0, 65535);
        $display("limit FFFF step a=0 at cycle %0d", k);
        step(65538);
        chk("limmax_before_z", {31'b0, z}, 32'd1);
        chk("limmax_busy", {31'b0, busy}, 32'd1);
        step(1);
        chk("limmax_after_z", {31'b0, z}, 32'd0);
        step(3);

        // Enable dropped mid-qualification, then restarted.
        cfg_limit = 16'd4;
        a = 1'b1;
        $display("enable test a=1 at cycle %0d", cyc);
        step(5);
        chk("en_busy_cnt2", {31'b0, busy}, 32'd1);
        en = 1'b0;
        step(1);
        chk("en_off_busy", {31'b0, busy}, 32'd0);
        chk("en_off_z", {31'b0, z}, 32'd0);
        step(3);
        chk("en_off_hold_z", {31'b0, z}, 32'd0);
        en = 1'b1;
        k = cyc;
        begin
            pulse_t p;
            p.is_rise = 1'b1;
            p.cyc     = k + 4 + 2;
            exp_q.push_back(p);
        end
        $display("re-enable at cycle %0d", k);
        step(5);
        chk("en_restart_z_pending", {31'b0, z}, 32'd0);
        step(3);
        chk("en_restart_z", {31'b0, z}, 32'd1);

        // Reset while qualifying a fall with z = 1.
        a = 1'b0;
        step(4);
        chk("midrst_busy", {31'b0, busy}, 32'd1);
        a = 1'b1;
        nreset = 1'b0;
        #1;
        chk("midrst_z", {31'b0, z}, 32'd0);
        chk("midrst_busy_clr", {31'b0, busy}, 32'd0);
        step(1);
        nreset = 1'b1;
        expect_pulse(1'b1, 4);
        $display("mid-op reset released at cycle %0d", cyc);
        step(10);
        chk("midrst_final_z", {31'b0, z}, 32'd1);

        chk("pending_pulses", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
